cbus_arbiter: RTL and testbench
===============================

Name: cbus_arbiter

Overview:
- Shares the single external cache bus between the I-side (fetch) and D-side (load/store) requesters.
- Grants one transaction at a time and latches the request.
- Routes response beats back to the owner; the owner's stall logic derives its i_wait/d_wait from these.
- Guarantees a started bus transaction always runs to completion, even if its requester is flushed mid-burst.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, data beat width
- LEN_W, 4, burst-length field width; beats = len+1
- STARVE_LIMIT, 4, consecutive D grants while I is pending before I is forced first

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ireq_valid  in  1  I-side request valid, held until its last response beat
- ireq_addr  in  ADDR_W  I-side address
- ireq_len  in  LEN_W  I-side burst length
- iresp_valid  out  1  response beat for I-side
- iresp_last  out  1  final I-side beat
- iresp_data  out  DATA_W  I-side read data
- dreq_valid  in  1  D-side request valid, held until its last beat
- dreq_is_write  in  1  D-side write
- dreq_addr  in  ADDR_W  D-side address
- dreq_len  in  LEN_W  D-side burst length
- dreq_strobe  in  DATA_W/8  D-side byte enables
- dreq_data  in  DATA_W  D-side write data for current beat
- dresp_valid  out  1  response beat for D-side
- dresp_last  out  1  final D-side beat
- dresp_data  out  DATA_W  D-side read data
- creq_valid  out  1  bus request valid
- creq_is_write  out  1  bus write
- creq_addr  out  ADDR_W  bus address (latched)
- creq_len  out  LEN_W  bus length (latched)
- creq_strobe  out  DATA_W/8  bus byte enables (latched)
- creq_data  out  DATA_W  bus write data (pass-through from dreq_data)
- cresp_ready  in  1  bus beat accepted/returned this cycle
- cresp_last  in  1  bus final beat
- cresp_data  in  DATA_W  bus read data
- owner  out  2  00 none, 01 I, 10 D

Behaviour:
- States: IDLE, I_BUSY, D_BUSY. Reset: IDLE, latches 0, starve counter 0, all outputs 0.
- IDLE grant order:
  - Starve counter == STARVE_LIMIT and ireq_valid: grant I.
  - Otherwise dreq_valid: grant D.
  - Otherwise ireq_valid: grant I.
- On grant: latch addr/len/write/strobe, set discard=0, move to X_BUSY. creq_valid rises the cycle after the grant (1-cycle grant latency).
- X_BUSY:
  - creq_valid=1 with the latched fields.
  - Each cycle with cresp_ready=1: owner's resp_valid=cresp_ready & ~discard; resp_data=cresp_data; resp_last=cresp_last. Non-owner resp outputs are 0.
  - cresp_ready & cresp_last: return to IDLE and clear discard. There is one mandatory IDLE bubble between transactions.
- Write beats: creq_data=dreq_data combinationally while D_BUSY, else 0.
- Flush mid-transaction: if the owner's req_valid drops while BUSY, set discard=1. The transaction continues on the bus; remaining beats are suppressed toward the requester.
  - If the same requester reasserts valid while discard=1, it waits. It is granted only after return to IDLE.
- Starve counter:
  - D grant while ireq_valid=1: increment, saturating at STARVE_LIMIT.
  - Any I grant: clear to 0.
  - D grant with ireq_valid=0: clear to 0.
- Simultaneous events:
  - cresp_last in the same cycle the owner drops valid: last beat suppressed, IDLE next cycle.
  - Reset asserted mid-burst: immediate return to IDLE, creq_valid=0. Bus-side recovery is the bus's responsibility.
- len=0: single-beat transaction, same FSM.
- Latched fields hold their last values in IDLE; creq_valid=0 there.

Optional Feature:
- CBUS_ARB_PERF_EN defined:
  - Adds outputs perf_i_wait[31:0] and perf_d_wait[31:0].
  - Each counts cycles with X_req_valid=1 and owner!=X (wrapping).
  - Adds perf_discard[15:0], counting discarded transactions (increments on completion with discard=1).
  - All counters reset to 0.
- Undefined: ports and counters absent; arbitration identical.

Decomposition:
- Package cbus_pkg holds:
  - cbus_req_t struct {valid,is_write,addr,len,strobe,data}
  - cbus_resp_t struct {ready,last,data}
  - arb_state_t enum {IDLE,I_BUSY,D_BUSY}
  - OWNER_NONE/I/D constants
- One sub-module, cbus_arb_fair: starve counter plus grant-select logic. Inputs ireq_valid, dreq_valid, grant_ev; outputs grant_i, grant_d.

Test Plan:
- I alone, len=3, bus returns 4 beats with cresp_ready=1 each cycle → owner=01 for 5 cycles; iresp_valid on 4 beats; iresp_last on the 4th; IDLE, then ready to grant again after the bubble.
- ireq_valid and dreq_valid asserted together in IDLE → D granted (owner=10); I granted after D's last beat plus 1 bubble cycle.
- D write len=1, strobe=0xF, dreq_data=0xA5A5A5A5 then 0x5A5A5A5A → creq_is_write=1; creq_data tracks each beat; dresp_last on beat 2.
- I request dropped after beat 1 of 4 → remaining 3 beats not visible on iresp_valid; creq_valid stays 1 until cresp_last; I re-request granted only after IDLE.
- I held pending while D issues 5 back-to-back requests, STARVE_LIMIT=4 → D granted 4 times, then I granted, then D.
- reset low mid D_BUSY beat 2 → next edge: owner=00, creq_valid=0, dresp_valid=0; with CBUS_ARB_PERF_EN, all perf counters read 0.

Source files
------------

// File: rtl/cbus_pkg.sv
// Shared types and constants for the cache-bus arbiter.
// Contents: bus request/response payload structs, arbiter state enum,
// owner encodings. Default widths match the cbus_arbiter parameter
// defaults; the arbiter's latched request register uses these widths.
package cbus_pkg;

    localparam int unsigned CBUS_ADDR_W = 32;
    localparam int unsigned CBUS_DATA_W = 32;
    localparam int unsigned CBUS_LEN_W  = 4;
    localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;

    // Bus-side request payload
    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [CBUS_LEN_W-1:0]  len;
        logic [CBUS_STRB_W-1:0] strobe;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_req_t;

    // Bus-side response beat
    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_I    = 2'b01;
    localparam logic [1:0] OWNER_D    = 2'b10;

endpackage

// File: rtl/cbus_arb_fair.sv
// Grant selection with I-side starvation protection.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ireq_valid        I-side request pending
//   dreq_valid        D-side request pending
//   grant_ev          arbiter is able to grant this cycle (IDLE)
//   grant_i, grant_d  one-hot grant decision (combinational)
// D wins by default; after STARVE_LIMIT consecutive D grants with I
// waiting, I is forced ahead once.
module cbus_arb_fair
    import cbus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ireq_valid,
    input  logic dreq_valid,
    input  logic grant_ev,
    output logic grant_i,
    output logic grant_d
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starved_c;

    assign starved_c = (starve_q == CNT_W'(STARVE_LIMIT));

    // Grant decision and starve counter update
    always_comb begin
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        starve_d = starve_q;
        if (grant_ev) begin
            if (starved_c && ireq_valid) begin
                grant_i = 1'b1;
            end else if (dreq_valid) begin
                grant_d = 1'b1;
            end else if (ireq_valid) begin
                grant_i = 1'b1;
            end

            if (grant_i) begin
                starve_d = '0;
            end else if (grant_d) begin
                if (!ireq_valid) begin
                    starve_d = '0;
                end else if (!starved_c) begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Arbiter sharing one external cache bus between I-side and D-side.
// One transaction at a time; request fields are latched at grant and the
// transaction always runs to the bus's last beat. If the owner drops its
// valid mid-burst, the remaining beats are swallowed (discard).
// Ports:
//   clk, reset                 clock, async active-low reset
//   ireq_* / iresp_*           I-side request in, response beats out
//   dreq_* / dresp_*           D-side request in, response beats out
//   creq_*                     bus request out (creq_data is live dreq_data)
//   cresp_*                    bus response beats in
//   owner                      00 none, 01 I, 10 D
// Optional: define CBUS_ARB_PERF_EN to add perf_i_wait, perf_d_wait and
// perf_discard counters.
// ADDR_W/DATA_W/LEN_W must equal the cbus_pkg widths.
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned ADDR_W       = CBUS_ADDR_W,
    parameter int unsigned DATA_W       = CBUS_DATA_W,
    parameter int unsigned LEN_W        = CBUS_LEN_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ireq_valid,
    input  logic [ADDR_W-1:0]     ireq_addr,
    input  logic [LEN_W-1:0]      ireq_len,
    output logic                  iresp_valid,
    output logic                  iresp_last,
    output logic [DATA_W-1:0]     iresp_data,
    input  logic                  dreq_valid,
    input  logic                  dreq_is_write,
    input  logic [ADDR_W-1:0]     dreq_addr,
    input  logic [LEN_W-1:0]      dreq_len,
    input  logic [DATA_W/8-1:0]   dreq_strobe,
    input  logic [DATA_W-1:0]     dreq_data,
    output logic                  dresp_valid,
    output logic                  dresp_last,
    output logic [DATA_W-1:0]     dresp_data,
    output logic                  creq_valid,
    output logic                  creq_is_write,
    output logic [ADDR_W-1:0]     creq_addr,
    output logic [LEN_W-1:0]      creq_len,
    output logic [DATA_W/8-1:0]   creq_strobe,
    output logic [DATA_W-1:0]     creq_data,
    input  logic                  cresp_ready,
    input  logic                  cresp_last,
    input  logic [DATA_W-1:0]     cresp_data,
    output logic [1:0]            owner
`ifdef CBUS_ARB_PERF_EN
    ,
    output logic [31:0]           perf_i_wait,
    output logic [31:0]           perf_d_wait,
    output logic [15:0]           perf_discard
`endif
);

    arb_state_t state_q, state_d;
    cbus_req_t  req_q, req_d;
    cbus_req_t  creq_c;
    cbus_resp_t cresp_c;
    logic       discard_q, discard_d;
    logic [1:0] owner_q, owner_d;
    logic       grant_ev_c, grant_i_c, grant_d_c;
    logic       own_valid_c, suppress_c, beat_c, done_c;

    assign cresp_c.ready = cresp_ready;
    assign cresp_c.last  = cresp_last;
    assign cresp_c.data  = cresp_data;

    assign grant_ev_c = (state_q == IDLE);

    cbus_arb_fair #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fair (
        .clk        (clk),
        .rst_n      (reset),
        .ireq_valid (ireq_valid),
        .dreq_valid (dreq_valid),
        .grant_ev   (grant_ev_c),
        .grant_i    (grant_i_c),
        .grant_d    (grant_d_c)
    );

    // Next state, request latch and response routing
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        discard_d   = discard_q;
        owner_d     = owner_q;
        own_valid_c = 1'b0;
        suppress_c  = 1'b0;
        beat_c      = 1'b0;
        done_c      = 1'b0;
        iresp_valid = 1'b0;
        iresp_last  = 1'b0;
        iresp_data  = '0;
        dresp_valid = 1'b0;
        dresp_last  = 1'b0;
        dresp_data  = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_d_c) begin
                    state_d        = D_BUSY;
                    owner_d        = OWNER_D;
                    req_d.valid    = 1'b1;
                    req_d.is_write = dreq_is_write;
                    req_d.addr     = dreq_addr;
                    req_d.len      = dreq_len;
                    req_d.strobe   = dreq_strobe;
                    req_d.data     = '0;
                    discard_d      = 1'b0;
                end else if (grant_i_c) begin
                    state_d        = I_BUSY;
                    owner_d        = OWNER_I;
                    req_d.valid    = 1'b1;
                    req_d.is_write = 1'b0;
                    req_d.addr     = ireq_addr;
                    req_d.len      = ireq_len;
                    req_d.strobe   = '0;
                    req_d.data     = '0;
                    discard_d      = 1'b0;
                end
            end

            I_BUSY, D_BUSY: begin
                own_valid_c = (state_q == I_BUSY) ? ireq_valid : dreq_valid;
                // A drop in this very cycle already hides the current beat
                suppress_c  = discard_q | ~own_valid_c;
                beat_c      = cresp_c.ready & ~suppress_c;
                done_c      = cresp_c.ready & cresp_c.last;
                if (!own_valid_c) begin
                    discard_d = 1'b1;
                end

                if (state_q == I_BUSY) begin
                    iresp_valid = beat_c;
                    iresp_last  = beat_c & cresp_c.last;
                    iresp_data  = cresp_c.data;
                end else begin
                    dresp_valid = beat_c;
                    dresp_last  = beat_c & cresp_c.last;
                    dresp_data  = cresp_c.data;
                end

                if (done_c) begin
                    state_d     = IDLE;
                    owner_d     = OWNER_NONE;
                    req_d.valid = 1'b0;
                    discard_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                owner_d = OWNER_NONE;
            end
        endcase
    end

    // Latched fields go out as-is; write data streams live from D-side
    always_comb begin
        creq_c      = req_q;
        creq_c.data = (state_q == D_BUSY) ? dreq_data : '0;
    end

    assign creq_valid    = creq_c.valid;
    assign creq_is_write = creq_c.is_write;
    assign creq_addr     = creq_c.addr;
    assign creq_len      = creq_c.len;
    assign creq_strobe   = creq_c.strobe;
    assign creq_data     = creq_c.data;
    assign owner         = owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            discard_q <= 1'b0;
            owner_q   <= OWNER_NONE;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            discard_q <= discard_d;
            owner_q   <= owner_d;
        end
    end

`ifdef CBUS_ARB_PERF_EN
    logic [31:0] perf_i_wait_q, perf_d_wait_q;
    logic [15:0] perf_discard_q;

    // Wait-cycle and discarded-transaction counters, all wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_i_wait_q  <= '0;
            perf_d_wait_q  <= '0;
            perf_discard_q <= '0;
        end else begin
            if (ireq_valid && (owner_q != OWNER_I)) begin
                perf_i_wait_q <= perf_i_wait_q + 32'd1;
            end
            if (dreq_valid && (owner_q != OWNER_D)) begin
                perf_d_wait_q <= perf_d_wait_q + 32'd1;
            end
            if (done_c && suppress_c) begin
                perf_discard_q <= perf_discard_q + 16'd1;
            end
        end
    end

    assign perf_i_wait  = perf_i_wait_q;
    assign perf_d_wait  = perf_d_wait_q;
    assign perf_discard = perf_discard_q;
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed self-checking bench for cbus_arbiter.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_cbus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ireq_valid;
    logic [AW-1:0] ireq_addr;
    logic [LW-1:0] ireq_len;
    logic          iresp_valid;
    logic          iresp_last;
    logic [DW-1:0] iresp_data;
    logic          dreq_valid;
    logic          dreq_is_write;
    logic [AW-1:0] dreq_addr;
    logic [LW-1:0] dreq_len;
    logic [SW-1:0] dreq_strobe;
    logic [DW-1:0] dreq_data;
    logic          dresp_valid;
    logic          dresp_last;
    logic [DW-1:0] dresp_data;
    logic          creq_valid;
    logic          creq_is_write;
    logic [AW-1:0] creq_addr;
    logic [LW-1:0] creq_len;
    logic [SW-1:0] creq_strobe;
    logic [DW-1:0] creq_data;
    logic          cresp_ready;
    logic          cresp_last;
    logic [DW-1:0] cresp_data;
    logic [1:0]    owner;
`ifdef CBUS_ARB_PERF_EN
    logic [31:0]   perf_i_wait;
    logic [31:0]   perf_d_wait;
    logic [15:0]   perf_discard;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cbus_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .LEN_W        (LW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .ireq_len      (ireq_len),
        .iresp_valid   (iresp_valid),
        .iresp_last    (iresp_last),
        .iresp_data    (iresp_data),
        .dreq_valid    (dreq_valid),
        .dreq_is_write (dreq_is_write),
        .dreq_addr     (dreq_addr),
        .dreq_len      (dreq_len),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_valid   (dresp_valid),
        .dresp_last    (dresp_last),
        .dresp_data    (dresp_data),
        .creq_valid    (creq_valid),
        .creq_is_write (creq_is_write),
        .creq_addr     (creq_addr),
        .creq_len      (creq_len),
        .creq_strobe   (creq_strobe),
        .creq_data     (creq_data),
        .cresp_ready   (cresp_ready),
        .cresp_last    (cresp_last),
        .cresp_data    (cresp_data),
        .owner         (owner)
`ifdef CBUS_ARB_PERF_EN
        ,
        .perf_i_wait   (perf_i_wait),
        .perf_d_wait   (perf_d_wait),
        .perf_discard  (perf_discard)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive n bus beats for the current owner. If drop_at >= 0 the owner
    // drops valid on that beat and re-raises it on the next one; every beat
    // from drop_at on must stay hidden from the requester.
    task automatic beats(input bit d_side, input int n, input logic [31:0] base,
                         input int drop_at);
        logic vis;
        logic [31:0] exp_data;
        for (int b = 0; b < n; b++) begin
            if (b == drop_at) begin
                if (d_side) dreq_valid = 1'b0;
                else        ireq_valid = 1'b0;
            end
            if (drop_at >= 0 && b == drop_at + 1) begin
                if (d_side) dreq_valid = 1'b1;
                else        ireq_valid = 1'b1;
            end
            exp_data    = base + 32'(b);
            cresp_ready = 1'b1;
            cresp_last  = (b == n - 1);
            cresp_data  = exp_data;
            #1;
            vis = (drop_at < 0) || (b < drop_at);
            check("beat_creq_valid", 64'(creq_valid), 64'(1));
            if (d_side) begin
                check("dresp_valid", 64'(dresp_valid), 64'(vis));
                if (vis) begin
                    check("dresp_data", 64'(dresp_data), 64'(exp_data));
                    check("dresp_last", 64'(dresp_last), 64'(b == n - 1));
                end
                check("iresp_valid_idle", 64'(iresp_valid), 64'(0));
            end else begin
                check("iresp_valid", 64'(iresp_valid), 64'(vis));
                if (vis) begin
                    check("iresp_data", 64'(iresp_data), 64'(exp_data));
                    check("iresp_last", 64'(iresp_last), 64'(b == n - 1));
                end
                check("dresp_valid_idle", 64'(dresp_valid), 64'(0));
            end
            tick();
        end
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = '0;
    endtask

    logic [1:0] starve_exp [6];

    initial begin
        reset         = 1'b1;
        ireq_valid    = 1'b0;
        ireq_addr     = '0;
        ireq_len      = '0;
        dreq_valid    = 1'b0;
        dreq_is_write = 1'b0;
        dreq_addr     = '0;
        dreq_len      = '0;
        dreq_strobe   = '0;
        dreq_data     = '0;
        cresp_ready   = 1'b0;
        cresp_last    = 1'b0;
        cresp_data    = '0;
        starve_exp    = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_owner",       64'(owner),       64'(0));
        check("rst_creq_valid",  64'(creq_valid),  64'(0));
        check("rst_creq_addr",   64'(creq_addr),   64'(0));
        check("rst_creq_len",    64'(creq_len),    64'(0));
        check("rst_creq_data",   64'(creq_data),   64'(0));
        check("rst_iresp_valid", 64'(iresp_valid), 64'(0));
        check("rst_dresp_valid", 64'(dresp_valid), 64'(0));
`ifdef CBUS_ARB_PERF_EN
        check("rst_perf_i_wait",  64'(perf_i_wait),  64'(0));
        check("rst_perf_discard", 64'(perf_discard), 64'(0));
`endif
        reset = 1'b1;
        tick();

        // I alone, 4 beats; one latency cycle before the bus answers
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_1000;
        ireq_len   = 4'd3;
        #1;
        check("t1_grant_owner", 64'(owner), 64'(0));
        tick();
        check("t1_owner",       64'(owner),         64'(2'b01));
        check("t1_creq_valid",  64'(creq_valid),    64'(1));
        check("t1_creq_addr",   64'(creq_addr),     64'(32'h0000_1000));
        check("t1_creq_len",    64'(creq_len),      64'(3));
        check("t1_creq_wr",     64'(creq_is_write), 64'(0));
        check("t1_lat_iresp",   64'(iresp_valid),   64'(0));
        tick();
        beats(1'b0, 4, 32'h0000_0100, -1);
        ireq_valid = 1'b0;
        #1;
        check("t1_done_owner", 64'(owner),      64'(0));
        check("t1_done_creq",  64'(creq_valid), 64'(0));
        check("t1_hold_addr",  64'(creq_addr),  64'(32'h0000_1000));
        tick();

        // I and D together: D first, I after D's last beat plus a bubble
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_3000;
        ireq_len   = 4'd0;
        dreq_valid = 1'b1;
        dreq_addr  = 32'h0000_4000;
        dreq_len   = 4'd1;
        tick();
        check("t2_owner_d", 64'(owner),     64'(2'b10));
        check("t2_addr_d",  64'(creq_addr), 64'(32'h0000_4000));
        tick();
        beats(1'b1, 2, 32'h0000_0200, -1);
        dreq_valid = 1'b0;
        #1;
        check("t2_bubble", 64'(owner), 64'(0));
        tick();
        check("t2_owner_i", 64'(owner),     64'(2'b01));
        check("t2_addr_i",  64'(creq_addr), 64'(32'h0000_3000));
        check("t2_len_i",   64'(creq_len),  64'(0));
        tick();
        beats(1'b0, 1, 32'h0000_0300, -1);
        ireq_valid = 1'b0;
        tick();

        // D write, 2 beats, write data follows dreq_data per beat
        dreq_valid    = 1'b1;
        dreq_is_write = 1'b1;
        dreq_addr     = 32'h0000_5000;
        dreq_len      = 4'd1;
        dreq_strobe   = 4'hF;
        dreq_data     = 32'hA5A5_A5A5;
        tick();
        check("t3_owner",  64'(owner),         64'(2'b10));
        check("t3_wr",     64'(creq_is_write), 64'(1));
        check("t3_strobe", 64'(creq_strobe),   64'(4'hF));
        check("t3_wdata0", 64'(creq_data),     64'(32'hA5A5_A5A5));
        tick();
        cresp_ready = 1'b1;
        cresp_last  = 1'b0;
        #1;
        check("t3_beat0_data",  64'(creq_data),   64'(32'hA5A5_A5A5));
        check("t3_beat0_valid", 64'(dresp_valid), 64'(1));
        check("t3_beat0_last",  64'(dresp_last),  64'(0));
        tick();
        dreq_data  = 32'h5A5A_5A5A;
        cresp_last = 1'b1;
        #1;
        check("t3_beat1_data",  64'(creq_data),   64'(32'h5A5A_5A5A));
        check("t3_beat1_valid", 64'(dresp_valid), 64'(1));
        check("t3_beat1_last",  64'(dresp_last),  64'(1));
        tick();
        cresp_ready   = 1'b0;
        cresp_last    = 1'b0;
        dreq_valid    = 1'b0;
        dreq_is_write = 1'b0;
        #1;
        check("t3_idle_owner",  64'(owner),       64'(0));
        check("t3_idle_wdata",  64'(creq_data),   64'(0));
        check("t3_hold_strobe", 64'(creq_strobe), 64'(4'hF));
        tick();

        // I flushed after beat 1 of 4, re-requests while discarding
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_6000;
        ireq_len   = 4'd3;
        tick();
        check("t4_owner", 64'(owner), 64'(2'b01));
        tick();
        beats(1'b0, 4, 32'h0000_0600, 1);
        #1;
        check("t4_bubble_owner", 64'(owner),      64'(0));
        check("t4_bubble_creq",  64'(creq_valid), 64'(0));
        tick();
        check("t4_regrant", 64'(owner), 64'(2'b01));
        tick();
        beats(1'b0, 4, 32'h0000_0700, -1);
        ireq_valid = 1'b0;
        tick();

        // D drops valid on the very last beat: that beat is hidden
        dreq_valid = 1'b1;
        dreq_addr  = 32'h0000_8000;
        dreq_len   = 4'd1;
        tick();
        check("t5_owner", 64'(owner), 64'(2'b10));
        tick();
        beats(1'b1, 2, 32'h0000_0800, 1);
        #1;
        check("t5_idle", 64'(owner), 64'(0));
        tick();

        // I pending across back-to-back D requests
        ireq_valid = 1'b1;
        ireq_addr  = 32'h0000_9000;
        ireq_len   = 4'd0;
        dreq_valid = 1'b1;
        dreq_addr  = 32'h0000_A000;
        dreq_len   = 4'd0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t6_owner", 64'(owner), 64'(starve_exp[k]));
            tick();
            beats(starve_exp[k] == 2'b10, 1, 32'h0000_0900 + 32'(k * 16), -1);
        end
        ireq_valid = 1'b0;
        dreq_valid = 1'b0;
        #1;
        check("t6_end_owner", 64'(owner), 64'(0));
        tick();
        check("t6_no_grant", 64'(owner), 64'(0));
`ifdef CBUS_ARB_PERF_EN
        check("perf_discard_cnt", 64'(perf_discard), 64'(2));
`endif

        // Reset on beat 2 of a D burst
        dreq_valid = 1'b1;
        dreq_addr  = 32'h0000_B000;
        dreq_len   = 4'd3;
        tick();
        check("t7_owner", 64'(owner), 64'(2'b10));
        tick();
        cresp_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t7_async_owner", 64'(owner),       64'(0));
        check("t7_async_creq",  64'(creq_valid),  64'(0));
        check("t7_async_dresp", 64'(dresp_valid), 64'(0));
        tick();
        check("t7_owner_rst", 64'(owner),       64'(0));
        check("t7_creq_rst",  64'(creq_valid),  64'(0));
        check("t7_dresp_rst", 64'(dresp_valid), 64'(0));
`ifdef CBUS_ARB_PERF_EN
        check("t7_perf_i_wait",  64'(perf_i_wait),  64'(0));
        check("t7_perf_d_wait",  64'(perf_d_wait),  64'(0));
        check("t7_perf_discard", 64'(perf_discard), 64'(0));
`endif
        dreq_valid  = 1'b0;
        cresp_ready = 1'b0;
        reset       = 1'b1;
        tick();
        check("t7_post_owner", 64'(owner), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
